// File: rtl/alu_rr_sched.sv
// -----------------------------------------------------------------------------
// alu_rr_sched
//   Shares one 4-bit ALU between NREQ command sources. A round-robin arbiter
//   picks one requester at a time. The chosen operands are driven onto the ALU.
//   After ALU_LAT cycles the ALU result is captured and returned on a single
//   response channel, tagged with the requester id. Only one operation is in
//   flight at a time, so no new request is accepted until the response has
//   been taken.
//
// Ports
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready  per-requester handshake; req_ready is one-hot or zero
//   req_opcode           3 bits per requester, requester i at [3i+2:3i]
//   req_op1, req_op2     4 bits per requester, requester i at [4i+3:4i]
//   alu_opcode/op1/op2   operands driven to the shared ALU
//   alu_res              ALU result (4-bit result + carry)
//   rsp_valid/rsp_ready  response handshake
//   rsp_id, rsp_data     owning requester and captured ALU result
//   busy                 high whenever the scheduler is not idle
// -----------------------------------------------------------------------------
module alu_rr_sched #(
    parameter int NREQ    = 4,
    parameter int ID_W    = $clog2(NREQ),
    parameter int ALU_LAT = 1,
    parameter int RES_W   = 5
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [3*NREQ-1:0]    req_opcode,
    input  logic [4*NREQ-1:0]    req_op1,
    input  logic [4*NREQ-1:0]    req_op2,
    output logic [2:0]           alu_opcode,
    output logic [3:0]           alu_op1,
    output logic [3:0]           alu_op2,
    input  logic [RES_W-1:0]     alu_res,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [RES_W-1:0]     rsp_data,
    output logic                 busy
);

    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_gnt;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_alu_opcode;
    logic [3:0]         r_alu_op1;
    logic [3:0]         r_alu_op2;
    logic [RES_W-1:0]   r_rsp_data;

    logic [ID_W-1:0]    w_gnt;
    logic               w_any;
    logic [ID_W:0]      w_idx;

    // Round-robin search starting at r_rr_ptr; the first valid requester
    // encountered (modulo NREQ) wins, independent of its absolute index.
    always_comb begin
        w_gnt = '0;
        w_any = 1'b0;
        w_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_idx >= (ID_W+1)'(NREQ)) begin
                w_idx = w_idx - (ID_W+1)'(NREQ);
            end
            if (!w_any && req_valid[w_idx[ID_W-1:0]]) begin
                w_any = 1'b1;
                w_gnt = w_idx[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and the combinational grant. req_ready is only ever
    // raised in IDLE, so a granted requester's valid&ready is the accept.
    always_comb begin
        w_next_state = r_state;
        req_ready    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    req_ready[w_gnt] = 1'b1;
                    w_next_state     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // The ALU operand registers double as the request latch: loading them on
    // the accept edge makes them visible in ISSUE and keeps them unchanged
    // until the next accept, so the ALU inputs never toggle in between.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr_ptr     <= '0;
            r_gnt        <= '0;
            r_cnt        <= '0;
            r_alu_opcode <= '0;
            r_alu_op1    <= '0;
            r_alu_op2    <= '0;
            r_rsp_data   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt        <= w_gnt;
                        r_alu_opcode <= req_opcode[3*w_gnt +: 3];
                        r_alu_op1    <= req_op1[4*w_gnt +: 4];
                        r_alu_op2    <= req_op2[4*w_gnt +: 4];
                    end
                end
                S_ISSUE: begin
                    r_cnt <= CNT_W'(ALU_LAT - 1);
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_rsp_data <= alu_res;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rr_ptr <= (r_gnt == ID_W'(NREQ - 1)) ? '0 : r_gnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign alu_opcode = r_alu_opcode;
    assign alu_op1    = r_alu_op1;
    assign alu_op2    = r_alu_op2;
    assign rsp_valid  = (r_state == S_RESP);
    assign rsp_id     = r_gnt;
    assign rsp_data   = r_rsp_data;
    assign busy       = (r_state != S_IDLE);

endmodule
